// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// the per-stage control record that travels alongside the data.
package shift_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_ROL = 2'b00;
   localparam mode_t MODE_SLL = 2'b01;
   localparam mode_t MODE_ROR = 2'b10;
   localparam mode_t MODE_SRA = 2'b11;

   // Control part of a stage record; data and remaining count are sized by
   // the instantiating module because a package cannot be parameterised.
   typedef struct packed {
      logic  valid;
      logic  sign;
      mode_t mode;
   } stage_ctl_t;

endpackage

// File: rtl/shift_stage.sv
// One elastic pipeline stage: conditionally shifts by 2**STEP and holds the
// result in a register with its own valid/ready handshake.
module shift_stage
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned STEP  = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  stage_ctl_t                 in_ctl_i,
   input  logic [WIDTH-1:0]           in_data_i,
   input  logic [$clog2(WIDTH)-1:0]   in_cnt_i,
   output logic                       ready_c_o,
   input  logic                       out_ready_i,
   output stage_ctl_t                 out_ctl_o,
   output logic [WIDTH-1:0]           out_data_o,
   output logic [$clog2(WIDTH)-1:0]   out_cnt_o
);

   localparam int unsigned CNTW  = $clog2(WIDTH);
   localparam int unsigned SHIFT = 1 << STEP;

   stage_ctl_t        ctl_q, ctl_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  shifted_c;
   logic [WIDTH-1:0]  fill_c;
   logic              load_c;

   // Arithmetic fill uses the sign of the original operand, not the current MSB.
   always_comb begin
      fill_c    = in_ctl_i.sign ? ~({WIDTH{1'b1}} >> SHIFT) : '0;
      shifted_c = in_data_i;
      if (in_cnt_i[STEP]) begin
         case (in_ctl_i.mode)
            MODE_ROL: shifted_c = (in_data_i << SHIFT) | (in_data_i >> (WIDTH - SHIFT));
            MODE_SLL: shifted_c = in_data_i << SHIFT;
            MODE_ROR: shifted_c = (in_data_i >> SHIFT) | (in_data_i << (WIDTH - SHIFT));
            default:  shifted_c = (in_data_i >> SHIFT) | fill_c;
         endcase
      end
   end

   // Load when empty or when the current contents leave this cycle.
   always_comb begin
      load_c = !ctl_q.valid || out_ready_i;
      ctl_d  = ctl_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      if (load_c) begin
         ctl_d.valid = in_ctl_i.valid;
         if (in_ctl_i.valid) begin
            ctl_d       = in_ctl_i;
            data_d      = shifted_c;
            cnt_d       = in_cnt_i;
            cnt_d[STEP] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_q  <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         ctl_q  <= ctl_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign ready_c_o  = load_c;
   assign out_ctl_o  = ctl_q;
   assign out_data_o = data_q;
   assign out_cnt_o  = cnt_q;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined rotate/shift unit: one registered stage per shift-count bit,
// elastic valid/ready flow control with per-stage stall.
module shift_unit_pipe
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [$clog2(WIDTH)-1:0]  in_cnt,
   input  logic [1:0]                in_mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [1:0]                out_mode
);

   localparam int unsigned CNTW = $clog2(WIDTH);

   stage_ctl_t        ctl   [CNTW+1];
   logic [WIDTH-1:0]  data  [CNTW+1];
   logic [CNTW-1:0]   cnt   [CNTW+1];
   logic              ready [CNTW+1];

   // Nothing may be accepted while reset is held.
   assign ctl[0]      = '{valid: in_valid && !rst, sign: in_data[WIDTH-1], mode: in_mode};
   assign data[0]     = in_data;
   assign cnt[0]      = in_cnt;
   assign ready[CNTW] = out_ready;
   assign in_ready    = ready[0] && !rst;

   for (genvar k = 0; k < CNTW; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .STEP  (k)
      ) u_stage (
         .clk         (clk),
         .rst         (rst),
         .in_ctl_i    (ctl[k]),
         .in_data_i   (data[k]),
         .in_cnt_i    (cnt[k]),
         .ready_c_o   (ready[k]),
         .out_ready_i (ready[k+1]),
         .out_ctl_o   (ctl[k+1]),
         .out_data_o  (data[k+1]),
         .out_cnt_o   (cnt[k+1])
      );
   end

   assign out_valid = ctl[CNTW].valid;
   assign out_data  = data[CNTW];
   assign out_mode  = ctl[CNTW].mode;

   // Count and sign are fully consumed by the time the last stage is reached.
   wire unused_tail = ^{cnt[CNTW], ctl[CNTW].sign};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe (WIDTH=16): directed cases plus a random stream
// scored against a bit-at-a-time reference model.
module tb_shift_unit_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_cnt;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [1:0]  out_mode;

   shift_unit_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_cnt    (in_cnt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mode  (out_mode)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  mode;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc_n = 0;
   int          pops = 0;
   bit          last_in_fire;
   bit          use_dir;
   bit          chk_lat;
   logic [15:0] dir_exp;

   function automatic logic [15:0] ref_shift(input logic [1:0] m, input logic [15:0] d, input int c);
      logic [15:0] r;
      r = d;
      for (int i = 0; i < c; i++) begin
         case (m)
            2'b00:   r = {r[14:0], r[15]};
            2'b01:   r = {r[14:0], 1'b0};
            2'b10:   r = {r[0], r[15:1]};
            default: r = {d[15], r[15:1]};
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Score the current cycle's handshakes, then advance to the next negedge.
   task automatic tick();
      exp_t e;
      #1;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("spurious_out", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_mode", 32'(out_mode), 32'(e.mode));
            if (e.lat) chk("latency", 32'(cyc_n - e.acc), 32'd4);
            pops++;
         end
      end
      last_in_fire = in_valid && in_ready;
      if (last_in_fire) begin
         e.data = use_dir ? dir_exp : ref_shift(in_mode, in_data, int'(in_cnt));
         e.mode = in_mode;
         e.acc  = cyc_n;
         e.lat  = chk_lat;
         q.push_back(e);
      end
      @(posedge clk);
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic offer(input logic [1:0] m, input logic [15:0] d, input logic [3:0] c,
                        input logic [15:0] exp, input bit must_now);
      int n;
      in_valid = 1'b1;
      in_mode  = m;
      in_data  = d;
      in_cnt   = c;
      use_dir  = 1'b1;
      dir_exp  = exp;
      chk_lat  = 1'b1;
      n = 0;
      last_in_fire = 1'b0;
      while (!last_in_fire && n < 200) begin
         tick();
         n++;
      end
      if (!last_in_fire) chk("accept_timeout", 32'd0, 32'd1);
      else if (must_now) chk("no_stall", 32'(n), 32'd1);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   task automatic drain();
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 64) begin
         tick();
         n++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] rq_data [6];
      logic [1:0]  rq_mode [6];
      logic [3:0]  rq_cnt  [6];
      logic [15:0] held;
      bit          have_held;
      int          k, pops0, n, accepted;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 16'hDEAD;
      in_cnt    = 4'd3;
      in_mode   = 2'b00;
      out_ready = 1'b1;
      use_dir   = 1'b0;
      chk_lat   = 1'b0;
      dir_exp   = '0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_mode", 32'(out_mode), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Directed single transactions
      offer(2'b00, 16'h8001, 4'd1, 16'h0003, 1'b1);
      drain();
      offer(2'b10, 16'h0001, 4'd1, 16'h8000, 1'b1);
      drain();
      offer(2'b01, 16'h8001, 4'd4, 16'h0010, 1'b1);
      drain();
      offer(2'b11, 16'h8000, 4'd15, 16'hFFFF, 1'b1);
      drain();
      offer(2'b11, 16'h7FFF, 4'd15, 16'h0000, 1'b1);
      drain();

      // cnt 0 in all modes, back-to-back
      for (int m = 0; m < 4; m++) offer(2'(m), 16'hA5C3, 4'd0, 16'hA5C3, 1'b1);
      drain();

      // Full pipeline with consumer stalled
      use_dir = 1'b0;
      chk_lat = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rq_data[i] = 16'($urandom);
         rq_mode[i] = 2'($urandom);
         rq_cnt[i]  = 4'($urandom);
      end
      out_ready = 1'b0;
      k = 0;
      have_held = 1'b0;
      held = '0;
      pops0 = pops;
      for (int c = 0; c < 10; c++) begin
         in_valid = (k < 6);
         in_data  = rq_data[k % 6];
         in_mode  = rq_mode[k % 6];
         in_cnt   = rq_cnt[k % 6];
         tick();
         if (last_in_fire) k++;
         if (out_valid) begin
            if (!have_held) begin
               have_held = 1'b1;
               held = out_data;
            end else begin
               chk("stall_stable", 32'(out_data), 32'(held));
            end
         end
      end
      #1;
      chk("full_accepted", 32'(k), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      out_ready = 1'b1;
      n = 0;
      while ((k < 6 || q.size() > 0) && n < 50) begin
         in_valid = (k < 6);
         in_data  = rq_data[k % 6];
         in_mode  = rq_mode[k % 6];
         in_cnt   = rq_cnt[k % 6];
         tick();
         if (last_in_fire) k++;
         n++;
      end
      in_valid = 1'b0;
      chk("release_pops", 32'(pops - pops0), 32'd6);
      drain();

      // Reset with requests in flight
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         in_mode  = 2'($urandom);
         in_cnt   = 4'($urandom);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      chk("midrst_out_mode", 32'(out_mode), 32'd0);
      q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rerst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("no_stale", 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      offer(2'b00, 16'h0001, 4'd15, 16'h8000, 1'b1);
      drain();

      // Random stream with random backpressure
      use_dir  = 1'b0;
      chk_lat  = 1'b0;
      accepted = 0;
      n = 0;
      while (accepted < 10000 && n < 40000) begin
         in_valid  = ($urandom_range(3) != 0);
         in_data   = 16'($urandom);
         in_mode   = 2'($urandom);
         in_cnt    = 4'($urandom);
         out_ready = ($urandom_range(3) != 0);
         tick();
         if (last_in_fire) accepted++;
         n++;
      end
      chk("random_accepted", 32'(accepted), 32'd10000);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_unit_pipe.md
SHIFT_UNIT_PIPE -- requirements
Module: shift_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data width; SHALL be a power of two, 4..64.
REQ-002 Parameter CNTW, default $clog2(WIDTH), shift-count width; SHALL be derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit accepts request this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_cnt  input  CNTW  shift amount, 0..WIDTH-1.
REQ-009 in_mode  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRA.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 out_mode  output  2  mode travelling with the result.

Function
REQ-014 The pipeline SHALL have CNTW registered stages; stage k applies a shift by 2^k when the travelling cnt bit k is 1, otherwise a pass-through.
REQ-015 ROL SHALL wrap bits from MSB to LSB; SLL SHALL fill zeros at LSB; ROR SHALL wrap LSB to MSB; SRA SHALL fill with the operand's original bit WIDTH-1.
REQ-016 Each stage register SHALL carry valid, data, remaining cnt bits, mode, and the sign bit.
REQ-017 Transfer occurs on a handshake (valid && ready high in the same cycle); no other condition SHALL move data.
REQ-018 Stage k SHALL load when its register is empty or its contents leave this cycle (elastic, per-stage stall); in_ready = stage-0 load condition.
REQ-019 Latency SHALL be exactly CNTW cycles from input handshake to out_valid when out_ready stays high; throughput one result per cycle.
REQ-020 out_valid/out_data/out_mode SHALL be driven directly from the last stage register and SHALL hold stable while out_valid && !out_ready.
REQ-021 Full pipeline: with out_ready low, the unit SHALL accept exactly CNTW requests, then deassert in_ready; no request lost or duplicated.
REQ-022 Simultaneous output pop and input push on a full pipeline SHALL both complete in the same cycle.
REQ-023 in_cnt = 0 SHALL return in_data unchanged in every mode.
REQ-024 Results SHALL emerge in acceptance order.
REQ-025 in_data/in_cnt/in_mode SHALL be ignored while in_valid is low or in_ready is low.

Reset
REQ-026 On rst high all stage valid bits SHALL clear immediately (asynchronously), in-flight requests being discarded.
REQ-027 During and after reset: out_valid = 0, out_data = 0, out_mode = 00, in_ready = 1 from the first edge after rst falls.
REQ-028 Deassertion of rst SHALL be usable by the first following rising edge; no request accepted while rst high.

Structure
REQ-029 Package shift_pkg SHALL hold the mode encodings (MODE_ROL, MODE_SLL, MODE_ROR, MODE_SRA) and the stage-record typedef.
REQ-030 One sub-module, shift_stage (parameters WIDTH, STEP), SHALL implement one combinational shift plus its register and handshake; shift_unit_pipe SHALL instantiate CNTW of them.

Verification (WIDTH=16, out_ready high unless stated)
REQ-031 ROL 0x8001 cnt 1 -> 0x0003 exactly 4 cycles after handshake; ROR 0x0001 cnt 1 -> 0x8000.
REQ-032 SLL 0x8001 cnt 4 -> 0x0010; SRA 0x8000 cnt 15 -> 0xFFFF; SRA 0x7FFF cnt 15 -> 0x0000.
REQ-033 cnt 0, all four modes, data 0xA5C3 -> 0xA5C3 each, back-to-back, one result per cycle.
REQ-034 out_ready low 10 cycles while 6 requests offered -> 4 accepted, in_ready low after 4th, out_data stable; release -> 6 results in order, none dropped.
REQ-035 rst pulsed with 3 requests in flight -> out_valid 0 and out_data 0x0000 during reset, no stale result afterwards, next request ROL 0x0001 cnt 15 -> 0x8000.
REQ-036 Random stream of 10k requests with random out_ready against a reference model -> zero mismatches.
